adc_iq_demod: RTL and testbench



---
 rtl/adc_iq_demod_pkg.sv | 10 +
 rtl/adc_iq_demod_lo.sv | 54 +++++
 rtl/adc_iq_demod.sv | 113 +++++++++++
 tb/tb_adc_iq_demod.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_iq_demod_pkg.sv
// rtl/adc_iq_demod_pkg.sv - widths, LO constants and phase type shared by the tone paths
package adc_iq_demod_pkg;
   localparam int DEF_DATA_W = 14;
   localparam int DEF_LO_W   = 8;
   localparam int DEF_OUT_W  = 16;
   localparam int LO_PEAK    = 127;
   localparam int PHASE_W    = 8;

   typedef logic [PHASE_W-1:0] phase_t;
endpackage

// File: rtl/adc_iq_demod_lo.sv
// rtl/adc_iq_demod_lo.sv - lo_nco: 8-bit phase to registered cos/sin from a quarter-wave table
module lo_nco
   import adc_iq_demod_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  phase_t                      phase_i,
   output logic signed [DEF_LO_W-1:0]  cos_o,
   output logic signed [DEF_LO_W-1:0]  sin_o
);

   // round(127*sin(2*pi*k/256)) for k = 0..64
   function automatic logic [DEF_LO_W-1:0] quarter_mag(input logic [6:0] k);
      case (k)
         7'd0:  return 8'd0;   7'd1:  return 8'd3;   7'd2:  return 8'd6;   7'd3:  return 8'd9;
         7'd4:  return 8'd12;  7'd5:  return 8'd16;  7'd6:  return 8'd19;  7'd7:  return 8'd22;
         7'd8:  return 8'd25;  7'd9:  return 8'd28;  7'd10: return 8'd31;  7'd11: return 8'd34;
         7'd12: return 8'd37;  7'd13: return 8'd40;  7'd14: return 8'd43;  7'd15: return 8'd46;
         7'd16: return 8'd49;  7'd17: return 8'd51;  7'd18: return 8'd54;  7'd19: return 8'd57;
         7'd20: return 8'd60;  7'd21: return 8'd63;  7'd22: return 8'd65;  7'd23: return 8'd68;
         7'd24: return 8'd71;  7'd25: return 8'd73;  7'd26: return 8'd76;  7'd27: return 8'd78;
         7'd28: return 8'd81;  7'd29: return 8'd83;  7'd30: return 8'd85;  7'd31: return 8'd88;
         7'd32: return 8'd90;  7'd33: return 8'd92;  7'd34: return 8'd94;  7'd35: return 8'd96;
         7'd36: return 8'd98;  7'd37: return 8'd100; 7'd38: return 8'd102; 7'd39: return 8'd104;
         7'd40: return 8'd106; 7'd41: return 8'd107; 7'd42: return 8'd109; 7'd43: return 8'd111;
         7'd44: return 8'd112; 7'd45: return 8'd113; 7'd46: return 8'd115; 7'd47: return 8'd116;
         7'd48: return 8'd117; 7'd49: return 8'd118; 7'd50: return 8'd120; 7'd51: return 8'd121;
         7'd52: return 8'd122; 7'd53: return 8'd122; 7'd54: return 8'd123; 7'd55: return 8'd124;
         7'd56: return 8'd125; 7'd57: return 8'd125; 7'd58: return 8'd126; 7'd59: return 8'd126;
         7'd60: return 8'd126; 7'd61: return 8'd127; 7'd62: return 8'd127; 7'd63: return 8'd127;
         default: return DEF_LO_W'(LO_PEAK);
      endcase
   endfunction

   // Second and fourth quadrants mirror the index; the lower half-circle negates.
   function automatic logic [DEF_LO_W-1:0] sin_of(input phase_t p);
      logic [6:0]          k;
      logic [DEF_LO_W-1:0] mag;
      k   = p[6] ? (7'd64 - {1'b0, p[5:0]}) : {1'b0, p[5:0]};
      mag = quarter_mag(k);
      return p[7] ? -mag : mag;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cos_o <= '0;
         sin_o <= '0;
      end else begin
         cos_o <= sin_of(phase_i + 8'd64);
         sin_o <= sin_of(phase_i);
      end
   end

endmodule

// File: rtl/adc_iq_demod.sv
// rtl/adc_iq_demod.sv - ADC I/Q mixer against an internal LO with integrate-and-dump decimation
module adc_iq_demod
   import adc_iq_demod_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int LO_W   = DEF_LO_W,
   parameter int DEC    = 64,
   parameter int OUT_W  = DEF_OUT_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic signed [DATA_W-1:0]  din,
   input  logic                      din_valid,
   input  logic [7:0]                fr_step,
   input  logic                      phase_clr,
   output logic signed [OUT_W-1:0]   i_out,
   output logic signed [OUT_W-1:0]   q_out,
   output logic                      out_valid
);

   localparam int PROD_W = DATA_W + LO_W;
   localparam int CNT_W  = $clog2(DEC);
   localparam int ACC_W  = PROD_W + CNT_W;

   phase_t                    phase_q, phase_d;
   logic                      accept;
   logic signed [DATA_W-1:0]  din_q;
   logic                      v1_q, v2_q;
   logic signed [LO_W-1:0]    lo_cos, lo_sin;
   logic signed [PROD_W-1:0]  prod_i_q, prod_q_q;
   logic signed [ACC_W-1:0]   acc_i_q, acc_i_d, acc_q_q, acc_q_d;
   logic signed [ACC_W-1:0]   sum_i, sum_q;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic signed [OUT_W-1:0]   i_out_q, i_out_d, q_out_q, q_out_d;
   logic                      out_valid_q, out_valid_d;

   assign accept  = din_valid & ~phase_clr;
   assign phase_d = phase_clr ? '0 : (accept ? phase_q + fr_step : phase_q);

   lo_nco u_lo (
      .clk     (clk),
      .rst     (rst),
      .phase_i (phase_q),
      .cos_o   (lo_cos),
      .sin_o   (lo_sin)
   );

   assign sum_i = acc_i_q + {{CNT_W{prod_i_q[PROD_W-1]}}, prod_i_q};
   assign sum_q = acc_q_q + {{CNT_W{prod_q_q[PROD_W-1]}}, prod_q_q};

   always_comb begin
      acc_i_d     = acc_i_q;
      acc_q_d     = acc_q_q;
      cnt_d       = cnt_q;
      i_out_d     = i_out_q;
      q_out_d     = q_out_q;
      out_valid_d = 1'b0;
      if (phase_clr) begin
         acc_i_d = '0;
         acc_q_d = '0;
         cnt_d   = '0;
      end else if (v2_q) begin
         if (cnt_q == CNT_W'(DEC - 1)) begin
            // Top OUT_W bits == arithmetic shift by ACC_W-OUT_W, rounding toward -inf.
            i_out_d     = sum_i[ACC_W-1 -: OUT_W];
            q_out_d     = sum_q[ACC_W-1 -: OUT_W];
            out_valid_d = 1'b1;
            acc_i_d     = '0;
            acc_q_d     = '0;
            cnt_d       = '0;
         end else begin
            acc_i_d = sum_i;
            acc_q_d = sum_q;
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q     <= '0;
         din_q       <= '0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         prod_i_q    <= '0;
         prod_q_q    <= '0;
         acc_i_q     <= '0;
         acc_q_q     <= '0;
         cnt_q       <= '0;
         i_out_q     <= '0;
         q_out_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         din_q       <= din;
         v1_q        <= accept;
         v2_q        <= v1_q & ~phase_clr;
         prod_i_q    <= din_q * lo_cos;
         prod_q_q    <= din_q * lo_sin;
         acc_i_q     <= acc_i_d;
         acc_q_q     <= acc_q_d;
         cnt_q       <= cnt_d;
         i_out_q     <= i_out_d;
         q_out_q     <= q_out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign i_out     = i_out_q;
   assign q_out     = q_out_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adc_iq_demod.sv
// tb/tb_adc_iq_demod.sv - randomized bench for adc_iq_demod against a trig-based reference model
module tb_adc_iq_demod;

   localparam int DEC   = 64;
   localparam int SHIFT = 12;

   logic               clk = 1'b0;
   logic               rst;
   logic signed [13:0] din;
   logic               din_valid;
   logic [7:0]         fr_step;
   logic               phase_clr;
   logic signed [15:0] i_out, q_out;
   logic               out_valid;

   adc_iq_demod #(.DEC(DEC)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .fr_step   (fr_step),
      .phase_clr (phase_clr),
      .i_out     (i_out),
      .q_out     (q_out),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int     at;
      longint i;
      longint q;
   } exp_t;

   exp_t   pend[$];
   int     n_cmp = 0;
   int     n_mis = 0;
   int     cyc   = 0;
   int     n_pulse = 0;
   int     ph    = 0;
   int     mcnt  = 0;
   longint mi = 0, mq = 0;
   longint hold_i = 0, hold_q = 0;

   task automatic chk(input string tag, input longint got, input longint want);
      n_cmp++;
      if (got != want) begin
         n_mis++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   function automatic int lo_val(input int p, input bit is_sin);
      real a, r;
      a = 2.0 * 3.14159265358979 * p / 256.0;
      r = 127.0 * (is_sin ? $sin(a) : $cos(a));
      return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
   endfunction

   // One clock edge as seen by the model: mix, integrate, and schedule a dump
   // that becomes visible in the third cycle after the one carrying the sample.
   task automatic model_edge();
      int c, s;
      if (rst) return;
      if (phase_clr) begin
         while (pend.size() > 0 && pend[pend.size()-1].at >= cyc) void'(pend.pop_back());
         mi = 0; mq = 0; mcnt = 0; ph = 0;
      end else if (din_valid) begin
         c = lo_val(ph, 1'b0);
         s = lo_val(ph, 1'b1);
         mi += longint'(din) * c;
         mq += longint'(din) * s;
         mcnt++;
         if (mcnt == DEC) begin
            pend.push_back('{cyc + 2, mi >>> SHIFT, mq >>> SHIFT});
            mi = 0; mq = 0; mcnt = 0;
         end
         ph = (ph + int'(fr_step)) % 256;
      end
   endtask

   task automatic tick();
      bit exp_v;
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      exp_v = 1'b0;
      if (pend.size() > 0 && pend[0].at == cyc) begin
         exp_v  = 1'b1;
         hold_i = pend[0].i;
         hold_q = pend[0].q;
         void'(pend.pop_front());
      end
      if (out_valid) n_pulse++;
      chk("out_valid", out_valid, exp_v);
      chk("i_out", i_out, hold_i);
      chk("q_out", q_out, hold_q);
   endtask

   task automatic send(input int v, input int gap);
      din       = 14'(v);
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic async_reset();
      #2;
      rst = 1'b1;
      #1;
      pend.delete();
      mi = 0; mq = 0; mcnt = 0; ph = 0; hold_i = 0; hold_q = 0;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_i", i_out, 0);
      chk("async_rst_q", q_out, 0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int p0;
      rst = 1'b1; din = '0; din_valid = 1'b0; fr_step = '0; phase_clr = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      fr_step = 8'd0;
      repeat (DEC) send(1000, 0);
      repeat (4) tick();
      chk("dc_pos_i", i_out, 1984);
      chk("dc_pos_q", q_out, 0);

      repeat (DEC) send(-8192, 0);
      repeat (4) tick();
      chk("dc_neg_i", i_out, -16256);
      chk("dc_neg_q", q_out, 0);

      fr_step = 8'd64;
      repeat (DEC) send(1000, 0);
      repeat (4) tick();
      chk("quarter_i", i_out, 0);
      chk("quarter_q", q_out, 0);

      p0 = n_pulse;
      for (int k = 0; k < 2 * DEC; k++)
         send((k % 4 == 0) ? 7747 : ((k % 4 == 2) ? -7747 : 0), 0);
      repeat (4) tick();
      chk("tone_pulses", n_pulse - p0, 2);
      chk("tone_i", i_out, 7686);
      chk("tone_q", q_out, 0);

      fr_step = 8'd0;
      p0 = n_pulse;
      repeat (DEC) send(1000, 2);
      repeat (4) tick();
      chk("gap_pulses", n_pulse - p0, 1);
      chk("gap_i", i_out, 1984);

      fr_step = 8'd37;
      repeat (30) send(1000, 0);
      phase_clr = 1'b1; din_valid = 1'b1; din = 14'(5000);
      tick();
      phase_clr = 1'b0; din_valid = 1'b0;
      fr_step = 8'd0;
      p0 = n_pulse;
      repeat (DEC - 1) send(1000, 0);
      repeat (4) tick();
      chk("clr_no_early", n_pulse - p0, 0);
      send(1000, 0);
      repeat (4) tick();
      chk("clr_pulses", n_pulse - p0, 1);
      chk("clr_i", i_out, 1984);

      repeat (20) send(-3000, 0);
      async_reset();
      tick();
      p0 = n_pulse;
      repeat (DEC) send(1000, 0);
      repeat (4) tick();
      chk("post_rst_pulses", n_pulse - p0, 1);
      chk("post_rst_i", i_out, 1984);

      for (int n = 0; n < 3000; n++) begin
         din       = 14'($urandom);
         din_valid = ($urandom_range(3, 0) != 0);
         if ($urandom_range(15, 0) == 0) fr_step = 8'($urandom);
         phase_clr = ($urandom_range(599, 0) == 0);
         tick();
      end
      phase_clr = 1'b0;
      din_valid = 1'b0;
      repeat (5) tick();
      chk("random_drained", pend.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
